// File: rtl/rca_share_ctrl.sv
// rca_share_ctrl
//   Shares one combinational ripple-carry adder between two requesters.
//   A round-robin grant picks one pending request while idle, its operands
//   are registered onto the adder inputs, the controller waits SETTLE_CYCLES
//   clocks for the carry chain to settle and then captures sum/carry-out
//   into a valid/ready response tagged with the requester id.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   req{0,1}_valid/ready      request handshake (ready is combinational)
//   req{0,1}_x/_y/_cin        request operands
//   add_x/add_y/add_cin       registered operands driven to the adder
//   add_s/add_cout            adder result
//   rsp_valid/rsp_ready       response handshake
//   rsp_sum/rsp_cout/rsp_id   captured result and issuing requester
//   busy                      controller is not idle
module rca_share_ctrl #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_x,
    input  logic [WIDTH-1:0] req0_y,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_x,
    input  logic [WIDTH-1:0] req1_y,
    input  logic             req1_cin,
    output logic [WIDTH-1:0] add_x,
    output logic [WIDTH-1:0] add_y,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_s,
    input  logic             add_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_id,
    output logic             busy
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] cnt;
    logic          last_grant;

    logic any_valid;
    logic grant_id;
    logic accept;
    logic capture;
    logic release_rsp;

    // Round-robin: a lone requester always wins; with both pending, the one
    // that was not served last wins.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid)
            grant_id = ~last_grant;
        else
            grant_id = req1_valid;
    end

    assign accept      = (state == IDLE) && any_valid;
    assign capture     = (state == SETTLE) && (cnt == CW'(1));
    assign release_rsp = (state == RESP) && rsp_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (accept)      next_state = SETTLE;
            SETTLE:  if (capture)     next_state = RESP;
            RESP:    if (release_rsp) next_state = IDLE;
            default:                  next_state = IDLE;
        endcase
    end

    // Outputs decoded from state; ready only ever offered while idle.
    always_comb begin
        req0_ready = accept && !grant_id;
        req1_ready = accept &&  grant_id;
        busy       = (state != IDLE);
    end

    // Operand launch, settle counter, result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_x      <= '0;
            add_y      <= '0;
            add_cin    <= 1'b0;
            cnt        <= '0;
            last_grant <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_sum    <= '0;
            rsp_cout   <= 1'b0;
            rsp_id     <= 1'b0;
        end else begin
            if (accept) begin
                add_x      <= grant_id ? req1_x   : req0_x;
                add_y      <= grant_id ? req1_y   : req0_y;
                add_cin    <= grant_id ? req1_cin : req0_cin;
                rsp_id     <= grant_id;
                last_grant <= grant_id;
                cnt        <= CW'(SETTLE_CYCLES);
            end
            if (state == SETTLE)
                cnt <= cnt - CW'(1);
            if (capture) begin
                rsp_sum   <= add_s;
                rsp_cout  <= add_cout;
                rsp_valid <= 1'b1;
            end
            if (release_rsp)
                rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rca_share_ctrl.sv
module tb_rca_share_ctrl;

    localparam int W  = 32;
    localparam int SC = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready, req0_cin;
    logic          req1_valid, req1_ready, req1_cin;
    logic [W-1:0]  req0_x, req0_y, req1_x, req1_y;
    logic [W-1:0]  add_x, add_y, add_s, rsp_sum;
    logic          add_cin, add_cout, rsp_valid, rsp_ready, rsp_cout, rsp_id, busy;

    // second instance built with a one-clock settle time
    logic          s1_req0_valid, s1_req0_ready, s1_req1_ready;
    logic [W-1:0]  s1_req0_x, s1_req0_y, s1_add_x, s1_add_y, s1_add_s, s1_rsp_sum;
    logic          s1_add_cin, s1_add_cout, s1_rsp_valid, s1_rsp_ready, s1_rsp_cout, s1_rsp_id, s1_busy;

    int errors = 0;
    int checks = 0;
    int mdl_last;     // reference round-robin pointer

    always #5 clk = ~clk;

    // the shared adder the controller drives
    assign {add_cout, add_s}       = {1'b0, add_x} + {1'b0, add_y} + {{W{1'b0}}, add_cin};
    assign {s1_add_cout, s1_add_s} = {1'b0, s1_add_x} + {1'b0, s1_add_y} + {{W{1'b0}}, s1_add_cin};

    rca_share_ctrl #(.WIDTH(W), .SETTLE_CYCLES(SC)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y), .req1_cin(req1_cin),
        .add_x(add_x), .add_y(add_y), .add_cin(add_cin), .add_s(add_s), .add_cout(add_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
        .rsp_id(rsp_id), .busy(busy)
    );

    rca_share_ctrl #(.WIDTH(W), .SETTLE_CYCLES(1)) dut_s1 (
        .clk(clk), .rst(rst),
        .req0_valid(s1_req0_valid), .req0_ready(s1_req0_ready), .req0_x(s1_req0_x), .req0_y(s1_req0_y), .req0_cin(1'b0),
        .req1_valid(1'b0), .req1_ready(s1_req1_ready), .req1_x('0), .req1_y('0), .req1_cin(1'b0),
        .add_x(s1_add_x), .add_y(s1_add_y), .add_cin(s1_add_cin), .add_s(s1_add_s), .add_cout(s1_add_cout),
        .rsp_valid(s1_rsp_valid), .rsp_ready(s1_rsp_ready), .rsp_sum(s1_rsp_sum), .rsp_cout(s1_rsp_cout),
        .rsp_id(s1_rsp_id), .busy(s1_busy)
    );

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Runs one full operation through the main DUT and checks it against the
    // reference: grant choice, launched operands, latency, result, hold under
    // backpressure and handshake completion.
    task automatic run_op(input bit v0, input bit v1,
                          input logic [W-1:0] x0, input logic [W-1:0] y0, input bit c0,
                          input logic [W-1:0] x1, input logic [W-1:0] y1, input bit c1,
                          input int hold, output int got_id);
        int            exp_id, n;
        logic [W:0]    full;
        logic [W-1:0]  ex, ey;
        bit            ec;
        req0_valid = v0; req0_x = x0; req0_y = y0; req0_cin = c0;
        req1_valid = v1; req1_x = x1; req1_y = y1; req1_cin = c1;
        exp_id = (v0 && v1) ? 1 - mdl_last : (v1 ? 1 : 0);
        ex = exp_id ? x1 : x0; ey = exp_id ? y1 : y0; ec = exp_id ? c1 : c0;
        full = {1'b0, ex} + {1'b0, ey} + (W+1)'(ec);
        #1;
        checks++;
        if (req0_ready !== (exp_id == 0) || req1_ready !== (exp_id == 1) || busy !== 1'b0) begin
            errors++;
            $display("FAIL grant: ready0=%b ready1=%b busy=%b expected id %0d idle", req0_ready, req1_ready, busy, exp_id);
        end
        tick();
        mdl_last = exp_id;
        checks++;
        if (add_x !== ex || add_y !== ey || add_cin !== ec || busy !== 1'b1) begin
            errors++;
            $display("FAIL launch: add=%h/%h/%b busy=%b expected %h/%h/%b busy=1", add_x, add_y, add_cin, busy, ex, ey, ec);
        end
        n = 0;
        while (!rsp_valid && n < 40) begin
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                errors++; checks++;
                $display("FAIL settle_ready: ready0=%b ready1=%b expected 0/0", req0_ready, req1_ready);
            end
            tick();
            n++;
        end
        checks++;
        if (n != SC) begin
            errors++;
            $display("FAIL latency: %0d clocks expected %0d", n, SC);
        end
        checks++;
        if (rsp_sum !== full[W-1:0] || rsp_cout !== full[W] || rsp_id !== exp_id[0]) begin
            errors++;
            $display("FAIL result: sum=%h cout=%b id=%b expected %h %b %0d", rsp_sum, rsp_cout, rsp_id, full[W-1:0], full[W], exp_id);
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_sum !== full[W-1:0] || rsp_cout !== full[W] || rsp_id !== exp_id[0]
                || busy !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold: vld=%b sum=%h cout=%b id=%b busy=%b rdy=%b%b expected 1 %h %b %0d 1 00",
                         rsp_valid, rsp_sum, rsp_cout, rsp_id, busy, req0_ready, req1_ready, full[W-1:0], full[W], exp_id);
            end
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_sum !== full[W-1:0] || add_x !== ex) begin
            errors++;
            $display("FAIL release: vld=%b busy=%b sum=%h add_x=%h expected 0 0 %h %h", rsp_valid, busy, rsp_sum, add_x, full[W-1:0], ex);
        end
        got_id = exp_id;
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if (add_x !== '0 || add_y !== '0 || add_cin !== 1'b0 || rsp_valid !== 1'b0 || rsp_sum !== '0
            || rsp_cout !== 1'b0 || rsp_id !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: add=%h/%h/%b rsp=%b/%h/%b/%b busy=%b expected all 0", tag,
                     add_x, add_y, add_cin, rsp_valid, rsp_sum, rsp_cout, rsp_id, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rsp_ready = 1'b0;
        req0_valid = 0; req1_valid = 0; req0_x = '0; req0_y = '0; req0_cin = 0;
        req1_x = '0; req1_y = '0; req1_cin = 0;
        s1_req0_valid = 0; s1_req0_x = '0; s1_req0_y = '0; s1_rsp_ready = 0;
        mdl_last = 1;
        repeat (3) tick();
        check_all_zero("reset_held");
        rst = 1'b0;
        repeat (2) tick();
        check_all_zero("reset_released");
    endtask

    task automatic test_carry_wrap();
        int id;
        run_op(1, 0, 32'hFFFF_FFFF, 32'h0000_0001, 0, '0, '0, 0, 0, id);
        checks++;
        if (rsp_sum !== 32'h0 || rsp_cout !== 1'b1 || id != 0) begin
            errors++;
            $display("FAIL carry_wrap: sum=%h cout=%b expected 00000000 1", rsp_sum, rsp_cout);
        end
    endtask

    task automatic test_cin();
        int id;
        run_op(0, 1, '0, '0, 0, 32'h7FFF_FFFF, 32'h0, 1, 1, id);
        checks++;
        if (rsp_sum !== 32'h8000_0000 || rsp_cout !== 1'b0 || rsp_id !== 1'b1) begin
            errors++;
            $display("FAIL cin: sum=%h cout=%b id=%b expected 80000000 0 1", rsp_sum, rsp_cout, rsp_id);
        end
    endtask

    task automatic test_dual_alternation();
        int id;
        rst = 1'b1; tick(); rst = 1'b0; mdl_last = 1; tick();
        for (int i = 0; i < 4; i++) begin
            run_op(1, 1, 32'(i * 3), 32'(100 + i), 0, 32'(i * 7), 32'(200 + i), 1, 0, id);
            checks++;
            if (id != (i % 2)) begin
                errors++;
                $display("FAIL alternation[%0d]: id=%0d expected %0d", i, id, i % 2);
            end
        end
    endtask

    task automatic test_backpressure();
        int id;
        run_op(1, 1, 32'hDEAD_BEEF, 32'h1234_5678, 1, 32'h1, 32'h2, 0, 10, id);
    endtask

    task automatic test_reset_mid();
        int id;
        run_op(1, 0, 32'h5, 32'h6, 0, '0, '0, 0, 0, id);  // pointer now at req0
        req0_valid = 1; req0_x = 32'hAAAA_0000; req0_y = 32'h5555; req0_cin = 0;
        tick();                       // accept, cnt = 4
        req0_valid = 0;
        tick(); tick();               // cnt = 2
        rst = 1'b1; #1;
        check_all_zero("reset_mid_async");
        tick();
        rst = 1'b0; mdl_last = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_drop: vld=%b busy=%b expected 0 0", rsp_valid, busy);
            end
        end
        run_op(1, 1, 32'h10, 32'h20, 0, 32'h30, 32'h40, 0, 0, id);
        checks++;
        if (id != 0 || rsp_id !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_grant: id=%b expected 0", rsp_id);
        end
    endtask

    task automatic test_settle1();
        s1_req0_valid = 1; s1_req0_x = 32'h1234_5678; s1_req0_y = 32'h1111_1111;
        #1;
        checks++;
        if (s1_req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL s1_ready: ready=%b expected 1", s1_req0_ready);
        end
        tick();
        s1_req0_valid = 0;
        checks++;
        if (s1_rsp_valid !== 1'b0 || s1_busy !== 1'b1) begin
            errors++;
            $display("FAIL s1_launch: vld=%b busy=%b expected 0 1", s1_rsp_valid, s1_busy);
        end
        tick();
        checks++;
        if (s1_rsp_valid !== 1'b1 || s1_rsp_sum !== 32'h2345_6789 || s1_rsp_cout !== 1'b0 || s1_rsp_id !== 1'b0) begin
            errors++;
            $display("FAIL s1_result: vld=%b sum=%h cout=%b id=%b expected 1 23456789 0 0",
                     s1_rsp_valid, s1_rsp_sum, s1_rsp_cout, s1_rsp_id);
        end
        s1_rsp_ready = 1; tick(); s1_rsp_ready = 0;
        checks++;
        if (s1_rsp_valid !== 1'b0 || s1_busy !== 1'b0) begin
            errors++;
            $display("FAIL s1_release: vld=%b busy=%b expected 0 0", s1_rsp_valid, s1_busy);
        end
    endtask

    task automatic test_random();
        int id;
        int r;
        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(1, 3);
            run_op(r[0], r[1], $urandom, $urandom, $urandom_range(0, 1) == 1,
                   $urandom, $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 3), id);
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    initial begin
        test_reset();
        test_carry_wrap();
        test_cin();
        test_dual_alternation();
        test_backpressure();
        test_reset_mid();
        test_settle1();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
